seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed hex driver for a common-anode or common-cathode 7-segment display bank of DIGITS digits. It decodes a packed nibble vector to segment patterns and scans one digit per slot, with anti-ghosting dead time and per-digit decimal points. It also provides leading-zero blanking and tear-free, frame-synchronous data update through a load/pending handshake. It sits between board-level switch/counter logic and the display pins.

---
 rtl/seg7_scan_driver.sv | 132 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a bank of 7-segment digits. Scans one digit per slot
// with dead time. New data is double-buffered and goes live only at a frame boundary.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int CLK_DIV  = 50000,
    parameter int DEAD     = 2,
    parameter int SEG_INV  = 0,
    parameter int LINE_INV = 0,
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_mask,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     line,
    output logic [IW-1:0]         digit_idx,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int   CW = $clog2(CLK_DIV);
    localparam logic SI = (SEG_INV != 0);
    localparam logic LI = (LINE_INV != 0);

    logic [CW-1:0]         cnt_reg;
    logic [4*DIGITS-1:0]   active_data_reg;
    logic [4*DIGITS-1:0]   shadow_data_reg;
    logic [DIGITS-1:0]     active_dp_reg;
    logic [DIGITS-1:0]     shadow_dp_reg;

    logic                  slot_end;
    logic                  boundary;
    logic                  digit_on;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [DIGITS-1:0]     line_next;

    logic [3:0]            nib [DIGITS];
    logic [DIGITS-1:0]     lz_blank;

    assign slot_end = (cnt_reg == CW'(CLK_DIV - 1));
    assign boundary = slot_end && (digit_idx == IW'(DIGITS - 1));

    // A digit is a leading zero when it and every more significant nibble are zero.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi] = active_data_reg[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = blank_lz && (active_data_reg[4*DIGITS-1 : 4*gi] == '0);
            end
        end
    endgenerate

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1111110;
            4'h1: decode = 7'b0110000;
            4'h2: decode = 7'b1101101;
            4'h3: decode = 7'b1111001;
            4'h4: decode = 7'b0110011;
            4'h5: decode = 7'b1011011;
            4'h6: decode = 7'b1011111;
            4'h7: decode = 7'b1110000;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1111011;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b0011111;
            4'hC: decode = 7'b1001110;
            4'hD: decode = 7'b0111101;
            4'hE: decode = 7'b1001111;
            default: decode = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        digit_on  = (cnt_reg >= CW'(DEAD)) && en_mask[digit_idx];
        seg_next  = 7'b0000000;
        dp_next   = 1'b0;
        line_next = '0;
        if (digit_on) begin
            seg_next  = lz_blank[digit_idx] ? 7'b0000000 : decode(nib[digit_idx]);
            dp_next   = active_dp_reg[digit_idx];
            line_next = DIGITS'(1) << digit_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg         <= '0;
            digit_idx       <= '0;
            active_data_reg <= '0;
            active_dp_reg   <= '0;
            shadow_data_reg <= '0;
            shadow_dp_reg   <= '0;
            pending         <= 1'b0;
            frame_tick      <= 1'b0;
            seg             <= {7{SI}};
            dp              <= SI;
            line            <= {DIGITS{LI}};
        end else begin
            cnt_reg <= slot_end ? '0 : cnt_reg + 1'b1;
            if (slot_end) begin
                digit_idx <= (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            end
            frame_tick <= boundary;
            // A load landing on the boundary still hands the older shadow to active.
            if (boundary && pending) begin
                active_data_reg <= shadow_data_reg;
                active_dp_reg   <= shadow_dp_reg;
            end
            if (load) begin
                shadow_data_reg <= data;
                shadow_dp_reg   <= dp_in;
                pending         <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            seg  <= seg_next ^ {7{SI}};
            dp   <= dp_next ^ SI;
            line <= line_next ^ {DIGITS{LI}};
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: stimulus queues the expected digit slots, monitors pop and compare
// each time a digit line goes active and then inactive again.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  en_mask0;
    logic [3:0]  en_mask1;
    logic        blank_lz;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  line0, line1;
    logic [1:0]  digit_idx0, digit_idx1;
    logic        frame_tick0, frame_tick1;
    logic        pending0, pending1;

    seg7_scan_driver #(.DIGITS(4), .CLK_DIV(8), .DEAD(2), .SEG_INV(0), .LINE_INV(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
        .en_mask(en_mask0), .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .line(line0),
        .digit_idx(digit_idx0), .frame_tick(frame_tick0), .pending(pending0)
    );

    seg7_scan_driver #(.DIGITS(4), .CLK_DIV(8), .DEAD(2), .SEG_INV(1), .LINE_INV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
        .en_mask(en_mask1), .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .line(line1),
        .digit_idx(digit_idx1), .frame_tick(frame_tick1), .pending(pending1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] line;
        logic [6:0] seg;
        logic       dp;
        int         len;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int mask_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push0(input logic [3:0] l, input logic [6:0] s, input logic d);
        exp_t e;
        e.line = l; e.seg = s; e.dp = d; e.len = 6;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [3:0] l, input logic [6:0] s, input logic d);
        exp_t e;
        e.line = l; e.seg = s; e.dp = d; e.len = 6;
        q1.push_back(e);
    endtask

    // Monitor for the active-high instance: one transaction per lit slot.
    logic       act0_prev = 1'b0;
    logic       in0 = 1'b0;
    int         run0 = 0;
    logic [3:0] cap0_line;
    logic [6:0] cap0_seg;
    logic       cap0_dp;

    always @(negedge clk) begin : mon0
        logic act;
        exp_t e;
        act = (line0 != 4'b0000);
        if (act && !act0_prev && q0.size() > 0) begin
            in0 = 1'b1; run0 = 1;
            cap0_line = line0; cap0_seg = seg0; cap0_dp = dp0;
        end else if (in0 && act) begin
            run0++;
        end else if (in0 && !act) begin
            e = q0.pop_front();
            in0 = 1'b0;
            check($sformatf("d0_line[%b]", e.line), cap0_line, e.line);
            check($sformatf("d0_seg[%b]", e.line), cap0_seg, e.seg);
            check($sformatf("d0_dp[%b]", e.line), cap0_dp, e.dp);
            check($sformatf("d0_len[%b]", e.line), run0, e.len);
        end
        act0_prev = act;
    end

    // Monitor for the inverted-polarity instance.
    logic       act1_prev = 1'b0;
    logic       in1 = 1'b0;
    int         run1 = 0;
    logic [3:0] cap1_line;
    logic [6:0] cap1_seg;
    logic       cap1_dp;

    always @(negedge clk) begin : mon1
        logic act;
        exp_t e;
        act = (line1 != 4'b1111);
        if (act && !act1_prev && q1.size() > 0) begin
            in1 = 1'b1; run1 = 1;
            cap1_line = line1; cap1_seg = seg1; cap1_dp = dp1;
        end else if (in1 && act) begin
            run1++;
        end else if (in1 && !act) begin
            e = q1.pop_front();
            in1 = 1'b0;
            check($sformatf("d1_line[%b]", e.line), cap1_line, e.line);
            check($sformatf("d1_seg[%b]", e.line), cap1_seg, e.seg);
            check($sformatf("d1_dp[%b]", e.line), cap1_dp, e.dp);
            check($sformatf("d1_len[%b]", e.line), run1, e.len);
        end
        act1_prev = act;
    end

    // Masked digits 1 and 3 of the inverted instance must never be driven low.
    always @(negedge clk) begin
        if (rst_n && (line1[1] !== 1'b1 || line1[3] !== 1'b1)) mask_bad++;
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        @(posedge clk);
        #1 load = 1'b1; data = d; dp_in = p;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_tick0) break;
        end
        check(name, frame_tick0, 1'b1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
        check(name, q0.size() + q1.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        clk = 1'b0; rst_n = 1'b0; load = 1'b0; data = '0; dp_in = '0;
        blank_lz = 1'b0; en_mask0 = 4'b1111; en_mask1 = 4'b0101;

        // Reset mid-frame with a pending load, checked before any clock edge.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        do_load(16'h4321, 4'b0000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_seg0", seg0, 7'b0000000);
        check("rst_dp0", dp0, 1'b0);
        check("rst_line0", line0, 4'b0000);
        check("rst_pending0", pending0, 1'b0);
        check("rst_tick0", frame_tick0, 1'b0);
        check("rst_idx0", digit_idx0, 2'd0);
        check("rst_seg1", seg1, 7'b1111111);
        check("rst_dp1", dp1, 1'b1);
        check("rst_line1", line1, 4'b1111);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        edges = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (line0 != 4'b0000) begin
                edges = i;
                break;
            end
        end
        check("release_latency", edges, 3);
        check("release_line0", line0, 4'b0001);
        check("release_seg0", seg0, 7'b1111110);
        check("release_pending0", pending0, 1'b0);

        // Scan 1234 on both instances.
        do_load(16'h1234, 4'b0000);
        check("scan_pending_set", pending0, 1'b1);
        wait_tick("scan_tick");
        check("scan_pending_clr", pending0, 1'b0);
        check("scan_idx0", digit_idx0, 2'd0);
        check("scan_tick1", frame_tick1, 1'b1);
        check("scan_idx1", digit_idx1, 2'd0);
        check("scan_pending1", pending1, 1'b0);
        @(posedge clk);
        #1;
        push0(4'b0001, 7'b0110011, 1'b0);
        push0(4'b0010, 7'b1111001, 1'b0);
        push0(4'b0100, 7'b1101101, 1'b0);
        push0(4'b1000, 7'b0110000, 1'b0);
        push1(4'b1110, 7'b1001100, 1'b1);
        push1(4'b1011, 7'b0010010, 1'b1);
        drain("scan_drain");

        // Handshake: second load overwrites the first before it is shown.
        do_load(16'hABCD, 4'b0000);
        @(negedge clk);
        check("hs_pending_a", pending0, 1'b1);
        repeat (2) @(posedge clk);
        do_load(16'h00EF, 4'b0000);
        @(negedge clk);
        check("hs_pending_b", pending0, 1'b1);
        wait_tick("hs_tick");
        check("hs_pending_clr", pending0, 1'b0);
        @(posedge clk);
        #1;
        push0(4'b0001, 7'b1000111, 1'b0);
        push0(4'b0010, 7'b1001111, 1'b0);
        push0(4'b0100, 7'b1111110, 1'b0);
        push0(4'b1000, 7'b1111110, 1'b0);
        drain("hs_drain");

        // Load colliding with the frame boundary.
        wait_tick("col_tick0");
        do_load(16'h5678, 4'b0000);
        repeat (29) @(posedge clk);
        #1 load = 1'b1; data = 16'h9C0D; dp_in = 4'b0000;
        @(posedge clk);
        #1 load = 1'b0;
        push0(4'b0001, 7'b1111111, 1'b0);
        push0(4'b0010, 7'b1110000, 1'b0);
        push0(4'b0100, 7'b1011111, 1'b0);
        push0(4'b1000, 7'b1011011, 1'b0);
        @(negedge clk);
        check("col_tick", frame_tick0, 1'b1);
        check("col_pending", pending0, 1'b1);
        wait_tick("col_tick2");
        check("col_pending_clr", pending0, 1'b0);
        @(posedge clk);
        #1;
        push0(4'b0001, 7'b0111101, 1'b0);
        push0(4'b0010, 7'b1111110, 1'b0);
        push0(4'b0100, 7'b1001110, 1'b0);
        push0(4'b1000, 7'b1111011, 1'b0);
        drain("col_drain");

        // Leading-zero blanking with a dp on a blanked digit.
        blank_lz = 1'b1;
        do_load(16'h0050, 4'b1000);
        wait_tick("lz_tick");
        @(posedge clk);
        #1;
        push0(4'b0001, 7'b1111110, 1'b0);
        push0(4'b0010, 7'b1011011, 1'b0);
        push0(4'b0100, 7'b0000000, 1'b0);
        push0(4'b1000, 7'b0000000, 1'b1);
        drain("lz_drain");

        check("mask_lines_inactive", mask_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
